// File: rtl/shift_register_pkg.sv
// Shared definitions for the serial-in / parallel-out shift register.
//   SHIFT_REGISTER_DEFAULT_WIDTH : default register width
//   shift_word_t                 : word type at the default width
package shift_register_pkg;
  localparam int SHIFT_REGISTER_DEFAULT_WIDTH = 8;
  typedef logic [SHIFT_REGISTER_DEFAULT_WIDTH-1:0] shift_word_t;
endpackage

// File: rtl/shift_register_if.sv
// Bus bundle for shift_register.
//   data, shift_enable : serial bit and its enable (master -> slave)
//   output_data        : parallel register contents (slave -> master)
//   load, load_data    : parallel load, only with SHIFT_REGISTER_PARALLEL_LOAD_EN
interface shift_register_if
  import shift_register_pkg::*;
#(
  parameter int WIDTH = SHIFT_REGISTER_DEFAULT_WIDTH
);
  logic             data;
  logic             shift_enable;
  logic [WIDTH-1:0] output_data;
`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_data;
`endif

  modport master (
    input  output_data,
    output data,
    output shift_enable
`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
    , output load
    , output load_data
`endif
  );

  modport slave (
    output output_data,
    input  data,
    input  shift_enable
`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
    , input load
    , input load_data
`endif
  );
endinterface

// File: rtl/shift_register_cell.sv
// One bit of the shift register: a flop with reset/load/shift priority mux.
//   clk, reset : clock, synchronous active-high reset
//   rst_val    : value taken on reset
//   load,load_d: parallel load strobe and bit
//   shift_en   : shift strobe; shift_d is the neighbour (or serial) bit
//   q          : stored bit
module shift_register_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic load,
  input  logic load_d,
  input  logic shift_en,
  input  logic shift_d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset)         q <= rst_val;
    else if (load)     q <= load_d;
    else if (shift_en) q <= shift_d;
  end
endmodule

// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register. Each enabled edge shifts the word
// one place toward the MSB and loads bus.data into bit 0; the old MSB drops.
// Optional parallel load when SHIFT_REGISTER_PARALLEL_LOAD_EN is defined
// (priority: reset > load > shift > hold).
//   clk   : clock, rising edge
//   reset : synchronous, active-high; loads RESET_VALUE
//   bus   : shift_register_if.slave (data, shift_enable, output_data,
//           load/load_data when enabled)
// The interface WIDTH parameter must match WIDTH here.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int               WIDTH       = SHIFT_REGISTER_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  shift_register_if.slave  bus
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] load_vec;
  logic             load_w;

  // Each cell takes its lower neighbour; cell 0 takes the serial input.
  assign shift_in = {q[WIDTH-2:0], bus.data};

`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
  assign load_w   = bus.load;
  assign load_vec = bus.load_data;
`else
  assign load_w   = 1'b0;
  assign load_vec = '0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_register_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .rst_val  (RESET_VALUE[i]),
      .load     (load_w),
      .load_d   (load_vec[i]),
      .shift_en (bus.shift_enable),
      .shift_d  (shift_in[i]),
      .q        (q[i])
    );
  end

  // Output comes straight from the flops: no input-to-output comb path.
  assign bus.output_data = q;
endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register (WIDTH=8). Stimulus pushes the
// hand-computed value expected after each edge; a monitor pops and compares
// just after every rising edge.
module tb_shift_register;
  import shift_register_pkg::*;

  typedef struct {
    shift_word_t val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   checks;
  int   failures;

  shift_register_if #(.WIDTH(8)) bus ();

  shift_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: output is always valid, so one expectation per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.output_data !== e.val) begin
        failures++;
        $display("FAIL %s: got=%h expected=%h", e.name, bus.output_data, e.val);
      end
    end
  end

  task automatic step(input logic r, input logic ld, input shift_word_t ldd,
                      input logic en, input logic d, input shift_word_t e,
                      input string n);
    @(negedge clk);
    reset            = r;
    bus.shift_enable = en;
    bus.data         = d;
`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
    bus.load         = ld;
    bus.load_data    = ldd;
`else
    if (ld) $display("note: load request %h ignored, feature disabled", ldd);
`endif
    exp_q.push_back('{e, n});
  endtask

  task automatic shift(input logic d, input shift_word_t e, input string n);
    step(1'b0, 1'b0, 8'h00, 1'b1, d, e, n);
  endtask

  initial begin
    shift_word_t ovf_exp [8];
    shift_word_t ones_exp[8];
    logic        a5_bits [8];
    shift_word_t a5_exp  [8];
    checks   = 0;
    failures = 0;
    reset            = 1'b1;
    bus.shift_enable = 1'b1;
    bus.data         = 1'b1;
`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
    bus.load         = 1'b0;
    bus.load_data    = 8'h00;
`endif

    // Reset held two edges with shift active
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "reset_edge1");
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "reset_edge2");

    // Serial pattern 1,0,1
    shift(1'b1, 8'b0000_0001, "serial_1");
    shift(1'b0, 8'b0000_0010, "serial_10");
    shift(1'b1, 8'b0000_0101, "serial_101");

    // Hold with data toggling
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 8'h00, 1'b0, logic'(i[0] == 1'b0), 8'b0000_0101, "hold");

    // Overflow: 1 then eight 0s from 8'h05; MSB dropped each shift
    shift(1'b1, 8'h0B, "ovf_one");
    ovf_exp = '{8'h16, 8'h2C, 8'h58, 8'hB0, 8'h60, 8'hC0, 8'h80, 8'h00};
    for (int i = 0; i < 8; i++) shift(1'b0, ovf_exp[i], "ovf_zero");

    // Eight 1s
    ones_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    for (int i = 0; i < 8; i++) shift(1'b1, ones_exp[i], "fill_ones");

    // Build 8'hA5 serially (MSB first), starting from 8'hFF
    a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    a5_exp  = '{8'hFF, 8'hFE, 8'hFD, 8'hFA, 8'hF4, 8'hE9, 8'hD2, 8'hA5};
    for (int i = 0; i < 8; i++) shift(a5_bits[i], a5_exp[i], "build_a5");

    // Reset beats shift in the same edge
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, "reset_priority");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, "post_reset_hold");

`ifdef SHIFT_REGISTER_PARALLEL_LOAD_EN
    // Load beats shift; then a shift of 1 on top of the loaded word
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, "load_over_shift");
    shift(1'b1, 8'h79, "shift_after_load");
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'hC3, "load_no_enable");
    step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h00, "reset_over_load");
`endif

    // Idle and drain the scoreboard
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "final_hold");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_register.md
# shift_register

Serial-in, parallel-out shift register with a shift enable. On each enabled rising clock edge it shifts its contents one position toward the MSB and loads the serial input bit into the LSB. The full register is always visible on a parallel output bus. It sits between a serial bit source and any consumer that needs the most recent WIDTH bits as a word.

## Interface
Parameters:
- `WIDTH`, default 8: register width in bits; legal range is 2 or more.
- `RESET_VALUE`, default `'0`: value loaded into the register on reset; WIDTH bits wide.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: reset is synchronous and active-high; it clears the register to RESET_VALUE.
- `data`, input, 1: serial input bit, shifted into bit 0.
- `shift_enable`, input, 1: when high at a rising edge, a shift occurs.
- `output_data`, output, WIDTH: current register contents, driven directly from the flops.
- `load`, input, 1: present only with SHIFT_REGISTER_PARALLEL_LOAD_EN.
- `load_data`, input, WIDTH: present only with SHIFT_REGISTER_PARALLEL_LOAD_EN.

## Operation
- State is a single WIDTH-bit register `q`, and `output_data = q`. There is no combinational path from the inputs to the output.
- At each rising edge of `clk`, exactly one of the following applies, in this priority order:
  - `reset` = 1: `q <= RESET_VALUE`.
  - `load` = 1 (feature enabled only): `q <= load_data`.
  - `shift_enable` = 1: `q <= {q[WIDTH-2:0], data}`. This is a left shift; the old MSB is discarded.
  - Otherwise: `q` holds its value.
- Reset overrides a shift or load asserted in the same cycle.
- Consecutive enabled cycles shift once per cycle. There is no rate limit and no handshake.
- Inputs with X/Z values are not required to be handled. After reset deasserts, the state is always known.

## Timing
- `output_data` reset value is RESET_VALUE (all zeros by default), visible after the first rising edge with `reset` high.
- Latency is one cycle. `data` and `shift_enable` are sampled at edge N, and the result appears on `output_data` after edge N.
- Inputs must meet setup and hold relative to the rising edge. Benches drive stimulus on the falling edge, or at least 1 time unit away from the rising edge.
- A bit written at edge N reaches `output_data[WIDTH-1]` after edge N+WIDTH-1, provided every intervening cycle is enabled. It is lost at the next enabled shift.
- Reset asserted mid-stream discards all shifted bits on that edge.

## Configuration
- Macro `SHIFT_REGISTER_PARALLEL_LOAD_EN`:
  - When defined: the `load` and `load_data` ports exist. `load` = 1 copies `load_data` into `q` in one cycle. `load` has priority over `shift_enable`; reset has priority over `load`.
  - When undefined: those ports are absent and the behaviour is pure serial-in.

## Structure
- Package `shift_register_pkg` holds:
  - `SHIFT_REGISTER_DEFAULT_WIDTH` = 8.
  - The typedef `shift_word_t` (`logic [SHIFT_REGISTER_DEFAULT_WIDTH-1:0]`).
- Optional leaf sub-module `shift_register_cell`: one flop with reset, load and enable muxing, instantiated WIDTH times in a generate loop. A single behavioral always block is equally acceptable.

## Test plan
- Reset: hold `reset` high for 2 edges with `shift_enable` = 1 and `data` = 1 → `output_data` = 8'h00.
- Serial pattern: from zero, shift in 1, then 0, then 1, one enabled edge each → `output_data` reads 8'b00000001, then 8'b00000010, then 8'b00000101.
- Hold: set `shift_enable` = 0 for 5 edges with `data` toggling → value unchanged at 8'b00000101.
- Overflow: shift in 1 followed by eight 0s → 8'h00, with the MSB dropped. Shift 1 eight times → 8'hFF.
- Reset priority: assert `reset` and `shift_enable` together while `q` = 8'hA5 → 8'h00 on the next edge.
- Load (feature enabled): `load` = 1, `load_data` = 8'h3C, `shift_enable` = 1 → 8'h3C. A subsequent shift of 1 gives 8'h79.
